// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between the arbiter (master) and its consumer (slave).
interface edge_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: latches per-channel edges as pending events and
// offers them one at a time, round-robin, through a single output register.
module edge_event_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  edge_event_arbiter_if.master evt,
  output logic [N-1:0]         overrun,
  input  logic                 clr_overrun
);

  logic [N-1:0]   a_r_q, a_r_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;
  logic           vld_q, vld_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;

  logic [N-1:0]   edge_det, above_mask, req_hi, load_mask;
  logic [IDW-1:0] winner;
  logic           accept, load;

  assign edge_det = a & ~a_r_q;
  assign accept   = vld_q & evt.evt_ready;
  assign load     = (~vld_q | accept) & (|pending_q);

  // Round-robin: prefer pending channels above the last grant, else wrap to the lowest.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < N; i++) above_mask[i] = (i > int'(last_q));
    req_hi = pending_q & above_mask;
    winner = '0;
    if (|req_hi) begin
      for (int i = N - 1; i >= 0; i--) if (req_hi[i]) winner = IDW'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--) if (pending_q[i]) winner = IDW'(i);
    end
  end

  always_comb begin
    load_mask = load ? (N'(1) << winner) : '0;
    a_r_d     = a;
    // A fresh edge re-arms the channel even if it is being loaded this cycle.
    pending_d = (pending_q & ~load_mask) | edge_det;
    overrun_d = (clr_overrun ? '0 : overrun_q) | (edge_det & pending_q & ~load_mask);
    vld_d     = vld_q;
    id_d      = id_q;
    last_d    = last_q;
    if (load) begin
      vld_d  = 1'b1;
      id_d   = winner;
      last_d = winner;
    end else if (accept) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      vld_q     <= 1'b0;
      id_q      <= '0;
      last_q    <= IDW'(N - 1);
    end else begin
      a_r_q     <= a_r_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      last_q    <= last_d;
    end
  end

  assign evt.evt_valid = vld_q;
  assign evt.evt_id    = id_q;
  assign overrun       = overrun_q;

endmodule
